// File: rtl/i2c_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | i2c_pkg : shared I2C encodings and constants for master and responder   |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_WR_DATA  = 3'd3,
      ST_WR_ACK   = 3'd4,
      ST_RD_DATA  = 3'd5,
      ST_RD_ACK   = 3'd6,
      ST_IGNORE   = 3'd7
   } state_t;

   localparam logic       ACK                 = 1'b0;
   localparam logic       NACK                = 1'b1;
   localparam logic [6:0] DEFAULT_SLAVE_ADDR  = 7'h50;
   localparam int         DEFAULT_SYNC_STAGES = 2;
   localparam int         SCL_DIV             = 10;

endpackage
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | i2c_sync_edge : pad synchroniser with rise/fall detect on synced level  |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module i2c_sync_edge
   import i2c_pkg::*;
#(
   parameter int STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Idle bus is pulled high, so reset to 1 to avoid a false edge after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_rx.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | i2c_slave_rx : 7-bit address I2C responder, write and read transfers    |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module i2c_slave_rx
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
   parameter int         SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   inout  wire        sda,
   input  logic       ack_en,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_req,
   output logic       busy,
   output logic       rw
);

   state_t     state;
   logic [3:0] cnt;
   logic [7:0] shreg;
   logic       sda_oe;
   logic       ack_hold;

   logic scl_s, scl_rise, scl_fall;
   logic sda_s, sda_rise, sda_fall;
   logic start_det, stop_det;
   logic [7:0] byte_in;

   i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
      .clk(clk), .reset(reset), .din(scl),
      .level(scl_s), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
      .clk(clk), .reset(reset), .din(sda),
      .level(sda_s), .rise(sda_rise), .fall(sda_fall)
   );

   assign start_det = sda_fall & scl_s;
   assign stop_det  = sda_rise & scl_s;
   assign byte_in   = {shreg[6:0], sda_s};

   // Reset gates the driver directly so SDA lets go in the cycle reset rises.
   assign sda = (sda_oe && !reset) ? 1'b0 : 1'bz;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= 4'd0;
         shreg    <= 8'h00;
         sda_oe   <= 1'b0;
         ack_hold <= 1'b0;
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
         busy     <= 1'b0;
         rw       <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         tx_req   <= 1'b0;
         if (start_det) begin
            state  <= ST_ADDR;
            cnt    <= 4'd0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else if (stop_det) begin
            state  <= ST_IDLE;
            cnt    <= 4'd0;
            sda_oe <= 1'b0;
            busy   <= 1'b0;
         end else begin
            case (state)
               ST_ADDR: if (scl_rise) begin
                  shreg <= byte_in;
                  if (cnt == 4'd7) begin
                     cnt <= 4'd0;
                     if (byte_in[7:1] == SLAVE_ADDR) begin
                        state <= ST_ADDR_ACK;
                        rw    <= byte_in[0];
                        busy  <= 1'b1;
                     end else begin
                        state <= ST_IGNORE;
                     end
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
               // Ack phases: cnt 0 = end of 8th clock, 1 = 9th low, 2 = 9th high.
               ST_ADDR_ACK: begin
                  if (scl_fall && cnt == 4'd0) begin
                     sda_oe <= 1'b1;
                     cnt    <= 4'd1;
                  end else if (scl_rise && cnt == 4'd1) begin
                     cnt    <= 4'd2;
                     tx_req <= rw;
                  end else if (scl_fall && cnt == 4'd2) begin
                     cnt <= 4'd0;
                     if (rw) begin
                        state  <= ST_RD_DATA;
                        sda_oe <= ~tx_data[7];
                        shreg  <= {tx_data[6:0], 1'b0};
                     end else begin
                        state  <= ST_WR_DATA;
                        sda_oe <= 1'b0;
                     end
                  end
               end
               ST_WR_DATA: if (scl_rise) begin
                  shreg <= byte_in;
                  if (cnt == 4'd7) begin
                     rx_data  <= byte_in;
                     rx_valid <= 1'b1;
                     ack_hold <= ack_en;
                     state    <= ST_WR_ACK;
                     cnt      <= 4'd0;
                  end else begin
                     cnt <= cnt + 4'd1;
                  end
               end
               ST_WR_ACK: begin
                  if (scl_fall && cnt == 4'd0) begin
                     sda_oe <= ack_hold;
                     cnt    <= 4'd1;
                  end else if (scl_rise && cnt == 4'd1) begin
                     cnt <= 4'd2;
                  end else if (scl_fall && cnt == 4'd2) begin
                     sda_oe <= 1'b0;
                     state  <= ST_WR_DATA;
                     cnt    <= 4'd0;
                  end
               end
               ST_RD_DATA: begin
                  if (scl_rise) begin
                     cnt <= cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (cnt == 4'd8) begin
                        state  <= ST_RD_ACK;
                        sda_oe <= 1'b0;
                        cnt    <= 4'd0;
                     end else begin
                        sda_oe <= ~shreg[7];
                        shreg  <= {shreg[6:0], 1'b0};
                     end
                  end
               end
               ST_RD_ACK: begin
                  if (scl_rise && cnt == 4'd0) begin
                     if (sda_s == ACK) begin
                        tx_req <= 1'b1;
                        cnt    <= 4'd1;
                     end else begin
                        state <= ST_IGNORE;
                     end
                  end else if (scl_fall && cnt == 4'd1) begin
                     state  <= ST_RD_DATA;
                     cnt    <= 4'd0;
                     sda_oe <= ~tx_data[7];
                     shreg  <= {tx_data[6:0], 1'b0};
                  end
               end
               ST_IDLE, ST_IGNORE: sda_oe <= 1'b0;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_rx.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_i2c_slave_rx : bus-level bench for i2c_slave_rx                      |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_i2c_slave_rx;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic       scl_m   = 1'b1;
   logic       sda_low = 1'b0;
   logic       ack_en  = 1'b1;
   logic [7:0] tx_data = 8'h00;
   wire        sda;
   logic [7:0] rx_data;
   logic       rx_valid, tx_req, busy, rw;

   assign sda = sda_low ? 1'b0 : 1'bz;
   pullup (sda);

   always #5 clk = ~clk;

   i2c_slave_rx #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .scl(scl_m), .sda(sda), .ack_en(ack_en),
      .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_req(tx_req), .busy(busy), .rw(rw)
   );

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic       aen;
      logic       exp_aack;
      logic       exp_dack;
      logic       exp_match;
   } vec_t;

   vec_t       vecs [6];
   int         total = 0;
   int         bad   = 0;
   int         tx_req_cnt = 0;
   logic [7:0] exp_rx [$];
   logic [7:0] tx_q [$];
   logic [7:0] last_rx = 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every rx_valid pops one expected byte; tx_req feeds the next tx byte.
   always @(negedge clk) begin
      if (rx_valid) begin
         if (exp_rx.size() == 0) begin
            total++;
            bad++;
            $display("FAIL rx_unexpected: got %0h expected no pulse", rx_data);
         end else begin
            check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
         end
      end
      if (tx_req) begin
         tx_req_cnt++;
         if (tx_q.size() > 0) tx_data = tx_q.pop_front();
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_bit(input logic b, output logic seen);
      wait_clk(3); sda_low = !b;
      wait_clk(2); scl_m = 1'b1;
      wait_clk(3); seen = sda;
      wait_clk(2); scl_m = 1'b0;
   endtask

   task automatic do_start;
      sda_low = 1'b0;
      wait_clk(3); scl_m = 1'b1;
      wait_clk(4); sda_low = 1'b1;
      wait_clk(4); scl_m = 1'b0;
   endtask

   task automatic do_stop;
      wait_clk(3); sda_low = 1'b1;
      wait_clk(2); scl_m = 1'b1;
      wait_clk(4); sda_low = 1'b0;
      wait_clk(6);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) do_bit(b[i], s);
      do_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         do_bit(1'b1, s);
         d[i] = s;
      end
      do_bit(!mack, s);
   endtask

   initial begin
      logic       a;
      logic       s;
      logic [7:0] d;

      vecs[0] = '{8'hA0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{8'hA2, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[2] = '{8'hA0, 8'h12, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{8'h00, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{8'hA0, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{8'hB0, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0};

      wait_clk(4);
      reset = 1'b0;
      wait_clk(2);
      check("rst_sda", {31'h0, sda}, 32'd1);
      check("rst_rx_data", {24'h0, rx_data}, 32'h0);
      check("rst_rx_valid", {31'h0, rx_valid}, 32'd0);
      check("rst_tx_req", {31'h0, tx_req}, 32'd0);
      check("rst_busy", {31'h0, busy}, 32'd0);
      check("rst_rw", {31'h0, rw}, 32'd0);

      foreach (vecs[k]) begin
         ack_en = vecs[k].aen;
         do_start;
         send_byte(vecs[k].addr, a);
         check("addr_ack", {31'h0, a}, {31'h0, vecs[k].exp_aack});
         check("busy_after_addr", {31'h0, busy}, {31'h0, vecs[k].exp_match});
         if (vecs[k].exp_match) begin
            exp_rx.push_back(vecs[k].data);
            last_rx = vecs[k].data;
         end
         send_byte(vecs[k].data, a);
         check("data_ack", {31'h0, a}, {31'h0, vecs[k].exp_dack});
         check("rx_hold", {24'h0, rx_data}, {24'h0, last_rx});
         do_stop;
         check("busy_after_stop", {31'h0, busy}, 32'd0);
         check("rx_pending", exp_rx.size(), 32'd0);
      end
      ack_en = 1'b1;

      // Read two bytes, master ACKs the first and NACKs the second.
      tx_q.push_back(8'h96);
      tx_q.push_back(8'h5A);
      tx_req_cnt = 0;
      do_start;
      send_byte(8'hA1, a);
      check("rd_addr_ack", {31'h0, a}, 32'd0);
      check("rd_rw", {31'h0, rw}, 32'd1);
      check("rd_busy", {31'h0, busy}, 32'd1);
      check("rd_txreq_addr", tx_req_cnt, 32'd1);
      read_byte(1'b1, d);
      check("rd_byte0", {24'h0, d}, 32'h96);
      check("rd_txreq_ack", tx_req_cnt, 32'd2);
      read_byte(1'b0, d);
      check("rd_byte1", {24'h0, d}, 32'h5A);
      check("rd_txreq_nack", tx_req_cnt, 32'd2);
      wait_clk(4);
      check("rd_release", {31'h0, sda}, 32'd1);
      do_stop;
      check("rd_busy_stop", {31'h0, busy}, 32'd0);

      // Write, then repeated START into a read without an intervening STOP.
      tx_q.push_back(8'hC3);
      tx_req_cnt = 0;
      do_start;
      send_byte(8'hA0, a);
      check("rs_wr_ack", {31'h0, a}, 32'd0);
      exp_rx.push_back(8'h11);
      send_byte(8'h11, a);
      check("rs_data_ack", {31'h0, a}, 32'd0);
      do_start;
      send_byte(8'hA1, a);
      check("rs_rd_ack", {31'h0, a}, 32'd0);
      check("rs_rw", {31'h0, rw}, 32'd1);
      check("rs_busy", {31'h0, busy}, 32'd1);
      check("rs_txreq", tx_req_cnt, 32'd1);
      read_byte(1'b0, d);
      check("rs_byte", {24'h0, d}, 32'hC3);
      do_stop;
      check("rs_pending", exp_rx.size(), 32'd0);

      // Reset during the 4th data bit of a write.
      do_start;
      send_byte(8'hA0, a);
      do_bit(1'b0, s);
      do_bit(1'b1, s);
      do_bit(1'b0, s);
      wait_clk(3); sda_low = 1'b0;
      wait_clk(2); scl_m = 1'b1;
      wait_clk(2); reset = 1'b1;
      #1;
      check("mid_rst_sda", {31'h0, sda}, 32'd1);
      wait_clk(1);
      check("mid_rst_busy", {31'h0, busy}, 32'd0);
      check("mid_rst_rw", {31'h0, rw}, 32'd0);
      check("mid_rst_rx_data", {24'h0, rx_data}, 32'h0);
      reset = 1'b0;
      wait_clk(1); scl_m = 1'b0;
      do_stop;

      // Reset while the responder is pulling SDA low for the address ACK.
      do_start;
      for (int i = 7; i >= 0; i--) do_bit(i == 7 || i == 5, s);
      wait_clk(3); sda_low = 1'b0;
      wait_clk(2); scl_m = 1'b1;
      wait_clk(1);
      check("ack_driven", {31'h0, sda}, 32'd0);
      reset = 1'b1;
      #1;
      check("ack_rst_release", {31'h0, sda}, 32'd1);
      wait_clk(1); reset = 1'b0;
      wait_clk(1); scl_m = 1'b0;
      do_stop;

      // Normal transfer after reset.
      do_start;
      send_byte(8'hA0, a);
      check("post_rst_ack", {31'h0, a}, 32'd0);
      exp_rx.push_back(8'h7E);
      send_byte(8'h7E, a);
      check("post_rst_data_ack", {31'h0, a}, 32'd0);
      do_stop;
      check("post_rst_rx", {24'h0, rx_data}, 32'h7E);
      check("post_rst_busy", {31'h0, busy}, 32'd0);
      check("final_pending", exp_rx.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
